// File: rtl/ex_pkg.sv
// ex_pkg -- shared constants and types for the EX stage with iterative MDU.
//   * ALU operation codes 0-15 and MDU operation codes 16-19
//   * MDU FSM state enum
//   * forwarding-select encodings plus the helper that picks a source
package ex_pkg;

   // ALU codes (0-15); unassigned codes behave as ADD
   localparam logic [4:0] ALU_ADD  = 5'd0;
   localparam logic [4:0] ALU_SUB  = 5'd1;
   localparam logic [4:0] ALU_SLL  = 5'd2;
   localparam logic [4:0] ALU_SLT  = 5'd3;
   localparam logic [4:0] ALU_SLTU = 5'd4;
   localparam logic [4:0] ALU_XOR  = 5'd5;
   localparam logic [4:0] ALU_SRL  = 5'd6;
   localparam logic [4:0] ALU_SRA  = 5'd7;
   localparam logic [4:0] ALU_OR   = 5'd8;
   localparam logic [4:0] ALU_AND  = 5'd9;
   localparam logic [4:0] ALU_LUI  = 5'd10;   // pass operand B

   // MDU codes: the low two bits select the operation inside mdu_iter
   localparam logic [4:0] MDU_MUL   = 5'd16;
   localparam logic [4:0] MDU_MULHU = 5'd17;
   localparam logic [4:0] MDU_DIVU  = 5'd18;
   localparam logic [4:0] MDU_REMU  = 5'd19;

   typedef enum logic [1:0] {
      MDU_IDLE = 2'd0,
      MDU_BUSY = 2'd1,
      MDU_DONE = 2'd2
   } mdu_state_t;

   // forwarding-select encodings
   localparam logic [1:0] FWD_REG = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   function automatic logic is_mdu_code(input logic [4:0] code);
      return (code[4:2] == 3'b100);
   endfunction

   // MEM has priority over WB; x0 is never forwarded
   function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                          input logic [4:0] rd_mem,
                                          input logic       we_mem,
                                          input logic [4:0] rd_wb,
                                          input logic       we_wb);
      if (we_mem && (rd_mem != 5'd0) && (rd_mem == rs))
         return FWD_MEM;
      else if (we_wb && (rd_wb != 5'd0) && (rd_wb == rs))
         return FWD_WB;
      else
         return FWD_REG;
   endfunction

endpackage

// File: rtl/alu.sv
// alu -- combinational single-cycle ALU for codes 0-15.
// Ports: i_code (operation), i_a / i_b (operands), o_y (result).
module alu
   import ex_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [4:0]      i_code,
   input  logic [XLEN-1:0] i_a,
   input  logic [XLEN-1:0] i_b,
   output logic [XLEN-1:0] o_y
);
   localparam int SHW = $clog2(XLEN);

   logic [SHW-1:0] w_shamt;
   assign w_shamt = i_b[SHW-1:0];

   always_comb begin
      o_y = i_a + i_b;
      case (i_code)
         ALU_SUB:  o_y = i_a - i_b;
         ALU_SLL:  o_y = i_a << w_shamt;
         ALU_SLT:  o_y = {{(XLEN-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
         ALU_SLTU: o_y = {{(XLEN-1){1'b0}}, (i_a < i_b)};
         ALU_XOR:  o_y = i_a ^ i_b;
         ALU_SRL:  o_y = i_a >> w_shamt;
         ALU_SRA:  o_y = $unsigned($signed(i_a) >>> w_shamt);
         ALU_OR:   o_y = i_a | i_b;
         ALU_AND:  o_y = i_a & i_b;
         ALU_LUI:  o_y = i_b;
         default:  o_y = i_a + i_b;
      endcase
   end
endmodule

// File: rtl/mdu_iter.sv
// mdu_iter -- iterative radix-2 multiply / restoring divide unit.
// Ports: clk, rst (async, active-high), i_start (request, honoured in IDLE),
//        i_flush (abort), i_op (00 MUL, 01 MULHU, 10 DIVU, 11 REMU),
//        i_a / i_b (operands), o_busy, o_done, o_result.
// The {r_hi, r_lo} pair holds the running product (multiply) or the
// remainder / shifting dividend-quotient (divide).
module mdu_iter
   import ex_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_start,
   input  logic            i_flush,
   input  logic [1:0]      i_op,
   input  logic [XLEN-1:0] i_a,
   input  logic [XLEN-1:0] i_b,
   output logic            o_busy,
   output logic            o_done,
   output logic [XLEN-1:0] o_result
);
   localparam int CNTW = $clog2(XLEN);

   mdu_state_t      r_state, w_state_next;
   logic [CNTW-1:0] r_cnt;
   logic [1:0]      r_op;
   logic [XLEN-1:0] r_hi, r_lo, r_b;

   logic [XLEN:0]   w_sum, w_rem_sh, w_diff;
   logic            w_ge;
   logic [XLEN-1:0] w_hi_next, w_lo_next;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= MDU_IDLE;
      else     r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         MDU_IDLE: if (i_start) w_state_next = MDU_BUSY;
         MDU_BUSY: begin
            if (i_flush)            w_state_next = MDU_IDLE;
            else if (r_cnt == '0)   w_state_next = MDU_DONE;
         end
         MDU_DONE: w_state_next = MDU_IDLE;
         default:  w_state_next = MDU_IDLE;
      endcase
   end

   // One iteration. Multiply: add multiplicand when the multiplier LSB is
   // set, then shift the whole product right (carry enters r_hi's MSB).
   // Divide: shift remainder left taking the next dividend bit, subtract
   // when possible; the quotient bit enters r_lo's LSB. A zero divisor
   // naturally yields quotient all-ones and remainder = dividend.
   always_comb begin
      w_sum    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
      w_rem_sh = {r_hi, r_lo[XLEN-1]};
      w_diff   = w_rem_sh - {1'b0, r_b};
      w_ge     = (w_rem_sh >= {1'b0, r_b});
      if (!r_op[1]) begin
         w_hi_next = w_sum[XLEN:1];
         w_lo_next = {w_sum[0], r_lo[XLEN-1:1]};
      end else begin
         w_hi_next = w_ge ? w_diff[XLEN-1:0] : w_rem_sh[XLEN-1:0];
         w_lo_next = {r_lo[XLEN-2:0], w_ge};
      end
   end

   // Datapath registers only move on acceptance or on a BUSY step, so they
   // hold their values while the EX stage runs ordinary ALU operations.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
         r_op  <= '0;
         r_hi  <= '0;
         r_lo  <= '0;
         r_b   <= '0;
      end else if (r_state == MDU_IDLE && i_start) begin
         r_cnt <= CNTW'(XLEN-1);
         r_op  <= i_op;
         r_hi  <= '0;
         r_lo  <= i_a;
         r_b   <= i_b;
      end else if (r_state == MDU_BUSY && !i_flush) begin
         r_hi  <= w_hi_next;
         r_lo  <= w_lo_next;
         if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
      end
   end

   assign o_busy   = (r_state == MDU_BUSY);
   assign o_done   = (r_state == MDU_DONE);
   // MULHU / REMU take the upper half, MUL / DIVU the lower half
   assign o_result = r_op[0] ? r_hi : r_lo;
endmodule

// File: rtl/ex_stage_mdu.sv
// ex_stage_mdu -- EX stage: operand forwarding, single-cycle ALU (codes
// 0-15) and optional iterative multiply/divide unit (codes 16-19).
// Ports: clk, reset (async, active-high); valid_ex / flush_ex; ALUCode_ex,
//        ALUSrcA_ex, ALUSrcB_ex; operand and forwarding-source data and
//        addresses; outputs ALUResult_ex, MemWriteData_ex (forwarded rs2),
//        result_valid_ex and stall_ex.
module ex_stage_mdu
   import ex_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int MDU_EN = 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            valid_ex,
   input  logic            flush_ex,
   input  logic [4:0]      ALUCode_ex,
   input  logic            ALUSrcA_ex,
   input  logic [1:0]      ALUSrcB_ex,
   input  logic [XLEN-1:0] Imm_ex,
   input  logic [XLEN-1:0] rs1Data_ex,
   input  logic [XLEN-1:0] rs2Data_ex,
   input  logic [XLEN-1:0] PC_ex,
   input  logic [XLEN-1:0] RegWriteData_wb,
   input  logic [XLEN-1:0] ALUResult_mem,
   input  logic [4:0]      rs1Addr_ex,
   input  logic [4:0]      rs2Addr_ex,
   input  logic [4:0]      rdAddr_mem,
   input  logic [4:0]      rdAddr_wb,
   input  logic            RegWrite_mem,
   input  logic            RegWrite_wb,
   output logic [XLEN-1:0] ALUResult_ex,
   output logic [XLEN-1:0] MemWriteData_ex,
   output logic            result_valid_ex,
   output logic            stall_ex
);
   logic [1:0]      w_sel_a, w_sel_b;
   logic [XLEN-1:0] w_fwd_a, w_fwd_b, w_op_a, w_op_b, w_alu_y;
   logic [4:0]      w_alu_code;
   logic            w_is_mdu, w_mdu_busy, w_mdu_done;
   logic [XLEN-1:0] w_mdu_res;

   assign w_sel_a = fwd_sel(rs1Addr_ex, rdAddr_mem, RegWrite_mem, rdAddr_wb, RegWrite_wb);
   assign w_sel_b = fwd_sel(rs2Addr_ex, rdAddr_mem, RegWrite_mem, rdAddr_wb, RegWrite_wb);

   always_comb begin
      case (w_sel_a)
         FWD_MEM: w_fwd_a = ALUResult_mem;
         FWD_WB:  w_fwd_a = RegWriteData_wb;
         default: w_fwd_a = rs1Data_ex;
      endcase
      case (w_sel_b)
         FWD_MEM: w_fwd_b = ALUResult_mem;
         FWD_WB:  w_fwd_b = RegWriteData_wb;
         default: w_fwd_b = rs2Data_ex;
      endcase
   end

   assign w_op_a = ALUSrcA_ex ? PC_ex : w_fwd_a;
   always_comb begin
      case (ALUSrcB_ex)
         2'd0:    w_op_b = w_fwd_b;
         2'd1:    w_op_b = Imm_ex;
         default: w_op_b = XLEN'(4);
      endcase
   end

   assign MemWriteData_ex = w_fwd_b;

   // MDU codes fall back to ADD in the ALU; with the MDU present the ALU
   // output is simply ignored for them.
   assign w_alu_code = is_mdu_code(ALUCode_ex) ? ALU_ADD : ALUCode_ex;
   assign w_is_mdu   = (MDU_EN != 0) && is_mdu_code(ALUCode_ex);

   alu #(.XLEN(XLEN)) u_alu (
      .i_code (w_alu_code),
      .i_a    (w_op_a),
      .i_b    (w_op_b),
      .o_y    (w_alu_y)
   );

   generate
      if (MDU_EN != 0) begin : g_mdu
         mdu_iter #(.XLEN(XLEN)) u_mdu (
            .clk      (clk),
            .rst      (reset),
            .i_start  (valid_ex & ~flush_ex & w_is_mdu),
            .i_flush  (flush_ex),
            .i_op     (ALUCode_ex[1:0]),
            .i_a      (w_fwd_a),
            .i_b      (w_fwd_b),
            .o_busy   (w_mdu_busy),
            .o_done   (w_mdu_done),
            .o_result (w_mdu_res)
         );
      end else begin : g_no_mdu
         assign w_mdu_busy = 1'b0;
         assign w_mdu_done = 1'b0;
         assign w_mdu_res  = '0;
      end
   endgenerate

   // A pending MDU operation (DONE/BUSY) owns the outputs; otherwise an MDU
   // code in IDLE is the acceptance cycle and stalls, and anything else is
   // a plain single-cycle ALU result. Reset forces both handshakes low.
   always_comb begin
      ALUResult_ex    = w_alu_y;
      result_valid_ex = 1'b0;
      stall_ex        = 1'b0;
      if (w_mdu_done) begin
         ALUResult_ex    = w_mdu_res;
         result_valid_ex = ~flush_ex;
      end else if (w_mdu_busy) begin
         stall_ex        = ~flush_ex;
      end else if (w_is_mdu) begin
         stall_ex        = valid_ex & ~flush_ex;
      end else begin
         result_valid_ex = valid_ex & ~flush_ex;
      end
      if (reset) begin
         result_valid_ex = 1'b0;
         stall_ex        = 1'b0;
      end
   end
endmodule

// File: tb/tb_ex_stage_mdu.sv
// tb_ex_stage_mdu -- scoreboard bench for ex_stage_mdu (XLEN=32, MDU on).
// Stimulus pushes expected {result, store data} when an instruction is
// issued; an independent negedge monitor pops and compares whenever the DUT
// raises result_valid_ex.
module tb_ex_stage_mdu;
   localparam int XLEN = 32;

   logic            clk = 1'b0;
   logic            reset;
   logic            valid_ex, flush_ex;
   logic [4:0]      ALUCode_ex;
   logic            ALUSrcA_ex;
   logic [1:0]      ALUSrcB_ex;
   logic [31:0]     Imm_ex, rs1Data_ex, rs2Data_ex, PC_ex, RegWriteData_wb, ALUResult_mem;
   logic [4:0]      rs1Addr_ex, rs2Addr_ex, rdAddr_mem, rdAddr_wb;
   logic            RegWrite_mem, RegWrite_wb;
   logic [31:0]     ALUResult_ex, MemWriteData_ex;
   logic            result_valid_ex, stall_ex;

   typedef struct packed {
      logic [31:0] res;
      logic [31:0] mwd;
   } exp_t;
   exp_t exp_q[$];

   int n_checks = 0;
   int n_err    = 0;

   always #5 clk = ~clk;

   ex_stage_mdu #(.XLEN(XLEN), .MDU_EN(1)) dut (
      .clk             (clk),
      .reset           (reset),
      .valid_ex        (valid_ex),
      .flush_ex        (flush_ex),
      .ALUCode_ex      (ALUCode_ex),
      .ALUSrcA_ex      (ALUSrcA_ex),
      .ALUSrcB_ex      (ALUSrcB_ex),
      .Imm_ex          (Imm_ex),
      .rs1Data_ex      (rs1Data_ex),
      .rs2Data_ex      (rs2Data_ex),
      .PC_ex           (PC_ex),
      .RegWriteData_wb (RegWriteData_wb),
      .ALUResult_mem   (ALUResult_mem),
      .rs1Addr_ex      (rs1Addr_ex),
      .rs2Addr_ex      (rs2Addr_ex),
      .rdAddr_mem      (rdAddr_mem),
      .rdAddr_wb       (rdAddr_wb),
      .RegWrite_mem    (RegWrite_mem),
      .RegWrite_wb     (RegWrite_wb),
      .ALUResult_ex    (ALUResult_ex),
      .MemWriteData_ex (MemWriteData_ex),
      .result_valid_ex (result_valid_ex),
      .stall_ex        (stall_ex)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
      end else begin
         $display("ok   %s: %0h (t=%0t)", name, act, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [31:0] fwd(input logic [4:0] addr, input logic [31:0] regval);
      if (RegWrite_mem && rdAddr_mem != 5'd0 && rdAddr_mem == addr) return ALUResult_mem;
      if (RegWrite_wb && rdAddr_wb != 5'd0 && rdAddr_wb == addr)    return RegWriteData_wb;
      return regval;
   endfunction

   function automatic logic [31:0] model_now();
      logic [31:0]        f1, f2, a, b;
      logic [63:0]        p;
      logic signed [31:0] sa;
      f1 = fwd(rs1Addr_ex, rs1Data_ex);
      f2 = fwd(rs2Addr_ex, rs2Data_ex);
      a  = ALUSrcA_ex ? PC_ex : f1;
      b  = (ALUSrcB_ex == 2'd0) ? f2 : (ALUSrcB_ex == 2'd1) ? Imm_ex : 32'd4;
      sa = a;
      p  = 64'(f1) * 64'(f2);
      case (ALUCode_ex)
         5'd1:    return a - b;
         5'd2:    return a << b[4:0];
         5'd3:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         5'd4:    return (a < b) ? 32'd1 : 32'd0;
         5'd5:    return a ^ b;
         5'd6:    return a >> b[4:0];
         5'd7:    return 32'(sa >>> b[4:0]);
         5'd8:    return a | b;
         5'd9:    return a & b;
         5'd10:   return b;
         5'd16:   return p[31:0];
         5'd17:   return p[63:32];
         5'd18:   return (f2 == 0) ? 32'hFFFF_FFFF : f1 / f2;
         5'd19:   return (f2 == 0) ? f1 : f1 % f2;
         default: return a + b;
      endcase
   endfunction

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (!reset && result_valid_ex) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL unexpected_result: got %0h required no result_valid_ex (t=%0t)", ALUResult_ex, $time);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("result", {32'd0, ALUResult_ex}, {32'd0, e.res});
            chk("store_data", {32'd0, MemWriteData_ex}, {32'd0, e.mwd});
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic set_plain(input logic [4:0] code, input logic [31:0] a, input logic [31:0] b);
      valid_ex = 1'b1; flush_ex = 1'b0; ALUCode_ex = code;
      ALUSrcA_ex = 1'b0; ALUSrcB_ex = 2'd0;
      rs1Addr_ex = 5'd1; rs2Addr_ex = 5'd2; rs1Data_ex = a; rs2Data_ex = b;
      rdAddr_mem = 5'd0; rdAddr_wb = 5'd0; RegWrite_mem = 1'b0; RegWrite_wb = 1'b0;
      Imm_ex = 32'd0; PC_ex = 32'h100; ALUResult_mem = 32'd0; RegWriteData_wb = 32'd0;
   endtask

   task automatic set_random(input logic [4:0] code);
      valid_ex = 1'b1; flush_ex = 1'b0; ALUCode_ex = code;
      ALUSrcA_ex = 1'($urandom_range(0, 1)); ALUSrcB_ex = 2'($urandom_range(0, 2));
      rs1Addr_ex = 5'($urandom_range(0, 3)); rs2Addr_ex = 5'($urandom_range(0, 3));
      rdAddr_mem = 5'($urandom_range(0, 3)); rdAddr_wb = 5'($urandom_range(0, 3));
      RegWrite_mem = 1'($urandom_range(0, 1)); RegWrite_wb = 1'($urandom_range(0, 1));
      rs1Data_ex = $urandom; rs2Data_ex = $urandom; Imm_ex = $urandom; PC_ex = $urandom;
      ALUResult_mem = $urandom; RegWriteData_wb = $urandom;
      if ($urandom_range(0, 1) == 1) begin
         rs2Data_ex = 32'($urandom_range(0, 300));
         ALUResult_mem = 32'($urandom_range(0, 300));
         RegWriteData_wb = 32'($urandom_range(0, 300));
      end
   endtask

   // Issue the instruction currently on the inputs. Entered and left at
   // posedge+1. flush_at >= 0 raises flush_ex in that cycle (0 = acceptance).
   task automatic run_op(input bit use_exp, input logic [31:0] exp_val, input int flush_at);
      logic [31:0] e;
      int          stalls;
      bit          done;
      e = use_exp ? exp_val : model_now();
      if (flush_at < 0) exp_q.push_back({e, fwd(rs2Addr_ex, rs2Data_ex)});
      if (ALUCode_ex < 5'd16) begin
         @(negedge clk);
         chk("alu_no_stall", {63'd0, stall_ex}, 64'd0);
         @(posedge clk); #1;
         valid_ex = 1'b0;
         return;
      end
      stalls = 0;
      done   = 1'b0;
      for (int c = 0; c < 3 * XLEN; c++) begin
         if (c == flush_at) flush_ex = 1'b1;
         @(negedge clk);
         if (c == flush_at) begin
            chk("flush_stall", {63'd0, stall_ex}, 64'd0);
            chk("flush_valid", {63'd0, result_valid_ex}, 64'd0);
            @(posedge clk); #1;
            flush_ex = 1'b0;
            done     = 1'b1;
            break;
         end
         if (result_valid_ex) begin
            chk("mdu_latency", 64'(c), 64'(XLEN + 1));
            chk("mdu_stall_cycles", 64'(stalls), 64'(XLEN + 1));
            chk("done_no_stall", {63'd0, stall_ex}, 64'd0);
            @(posedge clk); #1;
            done = 1'b1;
            break;
         end
         if (stall_ex) stalls++;
         @(posedge clk); #1;
      end
      if (!done) begin
         n_checks++;
         n_err++;
         $display("FAIL mdu_timeout: got no result_valid_ex required one within %0d cycles", 3 * XLEN);
      end
      valid_ex = 1'b0;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence ----------------
   initial begin
      reset = 1'b1;
      set_plain(5'd0, 32'd0, 32'd0);
      valid_ex = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("reset_stall", {63'd0, stall_ex}, 64'd0);
      chk("reset_valid", {63'd0, result_valid_ex}, 64'd0);
      @(posedge clk); #1;

      // forwarding: MEM beats WB
      set_plain(5'd0, 32'd1, 32'd3);
      rs1Addr_ex = 5'd5; rs2Addr_ex = 5'd6; rdAddr_mem = 5'd5; rdAddr_wb = 5'd5;
      RegWrite_mem = 1'b1; RegWrite_wb = 1'b1; ALUResult_mem = 32'd10; RegWriteData_wb = 32'd20;
      run_op(1'b1, 32'd13, -1);

      // x0 is never forwarded
      set_plain(5'd0, 32'd0, 32'd0);
      rs1Addr_ex = 5'd0; rdAddr_mem = 5'd0; RegWrite_mem = 1'b1; ALUResult_mem = 32'd99;
      rdAddr_wb = 5'd0; RegWrite_wb = 1'b1; RegWriteData_wb = 32'd55;
      ALUSrcB_ex = 2'd1; Imm_ex = 32'd7;
      run_op(1'b1, 32'd7, -1);

      // directed MDU cases
      set_plain(5'd16, 32'hFFFF_FFFF, 32'd2); run_op(1'b1, 32'hFFFF_FFFE, -1);
      set_plain(5'd17, 32'hFFFF_FFFF, 32'd2); run_op(1'b1, 32'h0000_0001, -1);
      set_plain(5'd18, 32'd100, 32'd7);       run_op(1'b1, 32'd14, -1);
      set_plain(5'd19, 32'd100, 32'd7);       run_op(1'b1, 32'd2, -1);
      set_plain(5'd18, 32'd5, 32'd0);         run_op(1'b1, 32'hFFFF_FFFF, -1);
      set_plain(5'd19, 32'd5, 32'd0);         run_op(1'b1, 32'd5, -1);

      // flush at BUSY cycle 10, then an ADD right away must complete
      set_plain(5'd18, 32'd1000, 32'd3); run_op(1'b0, 32'd0, 10);
      set_plain(5'd0, 32'd40, 32'd2);    run_op(1'b1, 32'd42, -1);

      // reset at BUSY cycle 5
      set_plain(5'd16, 32'h1234, 32'h5678);
      repeat (5) begin @(posedge clk); #1; end
      @(negedge clk);
      chk("busy_stall", {63'd0, stall_ex}, 64'd1);
      #1 reset = 1'b1; valid_ex = 1'b0;
      #1;
      chk("rst_stall", {63'd0, stall_ex}, 64'd0);
      chk("rst_valid", {63'd0, result_valid_ex}, 64'd0);
      @(posedge clk); #1 reset = 1'b0;
      repeat (XLEN + 4) @(posedge clk);
      #1;
      set_plain(5'd0, 32'd7, 32'd8); run_op(1'b1, 32'd15, -1);

      // randomized ALU and MDU traffic against the model
      for (int i = 0; i < 40; i++) begin
         set_random(5'($urandom_range(0, 15)));
         run_op(1'b0, 32'd0, -1);
      end
      for (int i = 0; i < 12; i++) begin
         set_random(5'($urandom_range(16, 19)));
         run_op(1'b0, 32'd0, -1);
      end

      repeat (3) @(posedge clk);
      #1;
      chk("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
